// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: size encodings, FSM states,
// the latched-request record and the size_bytes() helper.
// No ports; imported by dmem_arbiter and dmem_load_ext.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Request captured at the IDLE handshake; held unchanged until the response retires.
    typedef struct packed {
        logic        port;
        logic        write;
        logic [1:0]  size;     // normalised: never 2'd3
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load extractor: picks byte/half/word from the LSBs of a memory word and sign/zero extends.
// Purely combinational, zero latency; no handshake, so no backpressure.
// Ports: word_i (memory word), size_i (SZ_*), unsigned_i (1 = zero-extend), data_o (result).
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & word_i[7]}},  word_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & word_i[15]}}, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (port 0 = load/store unit, port 1 = debug/loader).
// Latency: accept at N, response at N+2 (N+1 for bad requests); one transaction in flight.
// Backpressure: req_ready only in IDLE and only to the granted port; RESP holds until rsp_ready.
// Ports: req_* request channel per port, rsp_* response channel, mem_* synchronous memory port.
// Build option: DMEM_ARB_RR_EN selects round-robin grant; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h01000000,
    parameter logic [31:0] MEM_BYTES = 32'h00010000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [3:0]  req_size,
    input  logic [1:0]  req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    state_t state_q, state_d;
    req_t   req_q, req_d;

    logic        grant;
    logic [1:0]  sel_size_raw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] end_addr;
    logic [31:0] ext_data;
    logic        mem_active;

`ifdef DMEM_ARB_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    // Contended cycle goes to rr_ptr; otherwise whichever port is asking.
    always_comb begin
        if (&req_valid) begin
            grant = rr_ptr_q;
        end else begin
            grant = req_valid[1] & ~req_valid[0];
        end
    end
`else
    always_comb begin
        grant = req_valid[1] & ~req_valid[0];
    end
`endif

    // Decode of the granted port's request.
    always_comb begin
        sel_size_raw = grant ? req_size[3:2] : req_size[1:0];
        sel_size     = (sel_size_raw == 2'd3) ? SZ_WORD : sel_size_raw;
        sel_addr     = grant ? req_addr[63:32] : req_addr[31:0];
        misaligned   = ((sel_size == SZ_HALF) && sel_addr[0]) ||
                       ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
        // 33-bit sums so an address near 2^32 cannot wrap back into range.
        end_addr     = {1'b0, sel_addr} + {30'd0, size_bytes(sel_size)};
        out_of_range = ({1'b0, sel_addr} < {1'b0, BASE}) ||
                       (end_addr > ({1'b0, BASE} + {1'b0, MEM_BYTES}));
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        req_ready = 2'b00;
`ifdef DMEM_ARB_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid[grant]) begin
                    req_ready   = grant ? 2'b10 : 2'b01;
                    req_d.port  = grant;
                    req_d.write = grant ? req_write[1] : req_write[0];
                    req_d.size  = sel_size;
                    req_d.uns   = grant ? req_unsigned[1] : req_unsigned[0];
                    req_d.addr  = sel_addr;
                    req_d.wdata = grant ? req_wdata[63:32] : req_wdata[31:0];
                    req_d.err   = misaligned | out_of_range;
                    state_d     = (misaligned | out_of_range) ? RESP : ACCESS;
`ifdef DMEM_ARB_RR_EN
                    rr_ptr_d    = ~grant;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[req_q.port]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
`ifdef DMEM_ARB_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    dmem_load_ext u_load_ext (
        .word_i     (mem_data_out),
        .size_i     (req_q.size),
        .unsigned_i (req_q.uns),
        .data_o     (ext_data)
    );

    // Address stays on the bus through RESP so the registered read word stays valid
    // while the response is backpressured. Bad requests never touch the memory.
    assign mem_active      = (state_q == ACCESS) || ((state_q == RESP) && !req_q.err);
    assign mem_address     = mem_active ? req_q.addr : 32'd0;
    assign mem_access_size = mem_active ? req_q.size : 2'd0;
    assign mem_read_write  = (state_q == ACCESS) && req_q.write;
    assign mem_data_in     = ((state_q == ACCESS) && req_q.write) ? req_q.wdata : 32'd0;

    assign rsp_valid = (state_q == RESP) ? (req_q.port ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_err   = (state_q == RESP) && req_q.err;
    assign rsp_rdata = ((state_q == RESP) && !req_q.write && !req_q.err) ? ext_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a byte-array reference model of memory contents.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE      = 32'h01000000;
    localparam logic [31:0] MEM_BYTES = 32'h00010000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [3:0]  req_size;
    logic [1:0]  req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int checks   = 0;
    int failures = 0;
    int both_vr  = 0;
    int bad_wr   = 0;
    bit bad_active = 1'b0;

    always #5 clock = ~clock;

    dmem_arbiter #(.BASE(BASE), .MEM_BYTES(MEM_BYTES)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_read_write  (mem_read_write),
        .mem_access_size (mem_access_size),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_data_out    (mem_data_out)
    );

    // Environment memory: registered little-endian read, posedge write of 1/2/4 bytes.
    logic [7:0]  mem [0:65535];
    logic [31:0] rd_word;
    assign mem_data_out = rd_word;

    always @(posedge clock) begin : env_mem
        logic [15:0] off;
        off = 16'(mem_address - BASE);
        rd_word <= {mem[off + 16'd3], mem[off + 16'd2], mem[off + 16'd1], mem[off]};
        if (mem_read_write) begin
            mem[off] = mem_data_in[7:0];
            if (mem_access_size != 2'd0) mem[off + 16'd1] = mem_data_in[15:8];
            if (mem_access_size >= 2'd2) begin
                mem[off + 16'd2] = mem_data_in[23:16];
                mem[off + 16'd3] = mem_data_in[31:24];
            end
        end
    end

    always @(negedge clock) begin
        if ((rsp_valid != 2'b00) && (req_ready != 2'b00)) both_vr++;
        if (bad_active && mem_read_write) bad_wr++;
    end

    // Reference model: expected memory contents as a plain byte array.
    logic [7:0] ref_mem [0:65535];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
        longint la = longint'(a);
        int     n  = nbytes(sz);
        if ((la % n) != 0) return 1'b1;
        if (la < longint'(BASE)) return 1'b1;
        if (la + n > longint'(BASE) + longint'(MEM_BYTES)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit un, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int n = nbytes(sz);
        int base_idx = int'(a - BASE);
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base_idx + i]) << (8 * i));
        if (!un && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int base_idx = int'(a - BASE);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[base_idx + i] = 8'(d >> (8 * i));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int p, input bit wr, input logic [1:0] sz, input bit un,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid[p]        = 1'b1;
        req_write[p]        = wr;
        req_size[2*p +: 2]  = sz;
        req_unsigned[p]     = un;
        req_addr[32*p +: 32]  = a;
        req_wdata[32*p +: 32] = wd;
    endtask

    // Waits for rsp_valid on port p (sampled 1 time unit after each posedge), starting
    // from the posedge that accepted the request; returns number of edges taken.
    task automatic wait_rsp(input int p, output int lat);
        lat = 1;
        while (!rsp_valid[p] && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    // One complete transaction: request, latency, response contents, hold, retire.
    task automatic do_txn(input string tag, input int p, input bit wr, input logic [1:0] sz,
                          input bit un, input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit          bad;
        logic [31:0] exp_rd;
        int          n;
        int          lat;
        int          wr_before;
        bad    = is_bad(sz, a);
        exp_rd = (bad || wr) ? 32'd0 : ref_load(sz, un, a);
        bad_active = bad;
        wr_before  = bad_wr;
        drive_req(p, wr, sz, un, a, wd);
        #1;
        n = 0;
        while (!req_ready[p] && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'(1 << p));
        if (!req_ready[p]) begin
            req_valid[p] = 1'b0;
            bad_active = 1'b0;
            return;
        end
        @(posedge clock); #1;
        req_valid[p] = 1'b0;
        wait_rsp(p, lat);
        check({tag, " latency"}, 32'(lat), bad ? 32'd1 : 32'd2);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << p));
        check({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(bad));
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'(1 << p));
            check({tag, " hold rsp_rdata"}, rsp_rdata, exp_rd);
            check({tag, " hold rsp_err"}, 32'(rsp_err), 32'(bad));
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready[p] = 1'b1;
        @(posedge clock); #1;
        rsp_ready[p] = 1'b0;
        check({tag, " retired"}, 32'(rsp_valid), 32'd0);
        if (bad) check({tag, " no mem write"}, 32'(bad_wr - wr_before), 32'd0);
        bad_active = 1'b0;
        if (!bad && wr) ref_store(sz, a, wd);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, " mem_rw"}, 32'(mem_read_write), 32'd0);
        check({tag, " mem_size"}, 32'(mem_access_size), 32'd0);
        check({tag, " mem_addr"}, mem_address, 32'd0);
        check({tag, " mem_din"}, mem_data_in, 32'd0);
    endtask

    initial begin : main
        int          lat;
        int          g;
        int          seen;
        int          exp_g;
        logic [31:0] exp_w [2];
        logic [31:0] a;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        reset_n = 1'b0;
        req_valid = '0; req_write = '0; req_size = '0; req_unsigned = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = '0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Word store then load.
        do_txn("sw", 0, 1'b1, 2'd2, 1'b0, 32'h01000010, 32'hDEADBEEF, 0);
        do_txn("lw", 0, 1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0, 0);
        // Byte store then signed and unsigned byte loads.
        do_txn("sb", 0, 1'b1, 2'd0, 1'b0, 32'h01000020, 32'h00000080, 0);
        do_txn("lb", 0, 1'b0, 2'd0, 1'b0, 32'h01000020, 32'h0, 0);
        do_txn("lbu", 0, 1'b0, 2'd0, 1'b1, 32'h01000020, 32'h0, 0);
        // Error cases and range boundaries.
        do_txn("lh misalign", 0, 1'b0, 2'd1, 1'b0, 32'h01000003, 32'h0, 0);
        do_txn("lw below", 0, 1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'h0, 0);
        do_txn("sw wrap", 1, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFC, 32'h11223344, 0);
        do_txn("sb past end", 1, 1'b1, 2'd0, 1'b0, BASE + MEM_BYTES, 32'h55, 0);
        do_txn("sw last", 1, 1'b1, 2'd2, 1'b0, BASE + MEM_BYTES - 32'd4, 32'hCAFEF00D, 0);
        do_txn("lh last", 1, 1'b0, 2'd1, 1'b0, BASE + MEM_BYTES - 32'd2, 32'h0, 0);
        // Backpressured load.
        do_txn("lw hold5", 0, 1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0, 5);

        // Contention: both ports valid continuously for six transactions.
        pulse_reset();
        exp_w[0] = ref_load(2'd2, 1'b0, 32'h01000010);
        exp_w[1] = ref_load(2'd2, 1'b0, 32'h01000020);
        drive_req(0, 1'b0, 2'd2, 1'b0, 32'h01000010, 32'h0);
        drive_req(1, 1'b0, 2'd2, 1'b0, 32'h01000020, 32'h0);
        #1;
        for (int k = 0; k < 6; k++) begin
            seen = 0;
            while (req_ready == 2'b00 && seen < 20) begin
                @(posedge clock); #1;
                seen++;
            end
            check("arb onehot", 32'($countones(req_ready)), 32'd1);
            g = req_ready[1] ? 1 : 0;
`ifdef DMEM_ARB_RR_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            check("arb grant", 32'(g), 32'(exp_g));
            @(posedge clock); #1;
            wait_rsp(g, lat);
            check("arb latency", 32'(lat), 32'd2);
            check("arb rdata", rsp_rdata, exp_w[g]);
            rsp_ready[g] = 1'b1;
            @(posedge clock); #1;
            rsp_ready[g] = 1'b0;
        end
        req_valid = 2'b00;
        @(posedge clock); #1;

        // Reset while a store sits in ACCESS.
        drive_req(0, 1'b1, 2'd2, 1'b0, 32'h01000040, 32'h12345678);
        #1;
        check("rst-access ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        req_valid = 2'b00;
        check("rst-access mem_rw", 32'(mem_read_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst-access");
        @(posedge clock); #1;
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            if (rsp_valid != 2'b00) seen++;
        end
        check("rst-access no rsp", 32'(seen), 32'd0);
        do_txn("resync sw", 0, 1'b1, 2'd2, 1'b0, 32'h01000040, 32'h0BADC0DE, 0);
        do_txn("resync lh", 0, 1'b0, 2'd1, 1'b0, 32'h01000042, 32'h0, 0);

        // Random traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + MEM_BYTES - 32'($urandom_range(0, 8));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                rsp_ready = 2'b11;   // must be ignored while nothing is pending
                @(posedge clock); #1;
                rsp_ready = 2'b00;
            end
            do_txn("rand", int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom),
                   1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        check("rsp_valid with req_ready", 32'(both_vr), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
